// File: rtl/instmem_arb_pkg.sv
// Shared types and defaults for the instmem arbiter: request kind and the
// response-pipeline stage record.
package instmem_arb_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 16;

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } req_kind_t;

    typedef struct packed {
        logic      valid;
        req_kind_t kind;
        logic      err;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{valid: 1'b0, kind: FETCH, err: 1'b0};

endpackage

// File: rtl/instmem_arbiter_if.sv
// Bus bundle between fetch unit, program loader, arbiter and instmem.
// slave = arbiter view, master = requesters plus memory view.
interface instmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) ();
    logic              fetch_req_valid;
    logic [ADDR_W-1:0] fetch_req_addr;
    logic              fetch_req_ready;
    logic              fetch_rsp_valid;
    logic [DATA_W-1:0] fetch_rsp_data;
    logic              fetch_rsp_err;

    logic              load_req_valid;
    logic [ADDR_W-1:0] load_req_addr;
    logic [DATA_W-1:0] load_req_data;
    logic              load_req_ready;
    logic              load_done;
    logic              load_err;

    logic              we_IM;
    logic [ADDR_W-1:0] addIM;
    logic [DATA_W-1:0] dataIM;
    logic [DATA_W-1:0] outIM;

    modport slave (
        input  fetch_req_valid, fetch_req_addr,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  load_req_valid, load_req_addr, load_req_data,
        output load_req_ready, load_done, load_err,
        output we_IM, addIM, dataIM,
        input  outIM
    );

    modport master (
        output fetch_req_valid, fetch_req_addr,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output load_req_valid, load_req_addr, load_req_data,
        input  load_req_ready, load_done, load_err,
        input  we_IM, addIM, dataIM,
        output outIM
    );
endinterface

// File: rtl/instmem_arb_grant.sv
// Two-way grant logic. IM_ARB_RR_EN selects round-robin with a last-granted
// pointer; otherwise the loader always wins.
module instmem_arb_grant
    import instmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_valid_i,
    input  logic load_valid_i,
    output logic fetch_ready_o,
    output logic load_ready_o
);

`ifdef IM_ARB_RR_EN
    req_kind_t last_q, last_d;
    logic      load_wins;

    // Loader wins uncontested, or under contention when fetch went last.
    assign load_wins     = load_valid_i & (~fetch_valid_i | (last_q == FETCH));
    assign load_ready_o  = rst_n & load_wins;
    assign fetch_ready_o = rst_n & ~load_wins;

    always_comb begin
        last_d = last_q;
        if (load_valid_i && load_ready_o)
            last_d = LOAD;
        else if (fetch_valid_i && fetch_ready_o)
            last_d = FETCH;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_q <= FETCH;
        else
            last_q <= last_d;
    end
`else
    logic unused_clk;

    assign unused_clk    = clk;
    assign load_ready_o  = rst_n & load_valid_i;
    assign fetch_ready_o = rst_n & ~load_valid_i;
`endif

endmodule

// File: rtl/instmem_arbiter.sv
// Arbiter/sequencer for single-port instmem: registered issue, 2-stage
// response pipeline. Optional round-robin grant via IM_ARB_RR_EN.
module instmem_arbiter
    import instmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input logic clk,
    input logic rst_n,
    instmem_arbiter_if.slave bus
);

    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    logic              fetch_ready, load_ready;
    logic              fetch_acc, load_acc;
    logic              fetch_oor, load_oor;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    stage_t            s1_q, s1_d, s2_q;
    logic              rsp_live, fetch_ok;

    instmem_arb_grant u_grant (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid_i (bus.fetch_req_valid),
        .load_valid_i  (bus.load_req_valid),
        .fetch_ready_o (fetch_ready),
        .load_ready_o  (load_ready)
    );

    assign bus.fetch_req_ready = fetch_ready;
    assign bus.load_req_ready  = load_ready;
    assign fetch_acc = bus.fetch_req_valid & fetch_ready;
    assign load_acc  = bus.load_req_valid & load_ready;
    assign fetch_oor = {1'b0, bus.fetch_req_addr} >= DEPTH_L;
    assign load_oor  = {1'b0, bus.load_req_addr} >= DEPTH_L;

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        s1_d   = STAGE_IDLE;
        if (load_acc) begin
            we_d   = ~load_oor;
            addr_d = bus.load_req_addr;
            data_d = bus.load_req_data;
            s1_d   = '{valid: 1'b1, kind: LOAD, err: load_oor};
        end else if (fetch_acc) begin
            addr_d = bus.fetch_req_addr;
            s1_d   = '{valid: 1'b1, kind: FETCH, err: fetch_oor};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            s1_q   <= STAGE_IDLE;
            s2_q   <= STAGE_IDLE;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            s1_q   <= s1_d;
            s2_q   <= s1_q;
        end
    end

    assign bus.we_IM  = we_q;
    assign bus.addIM  = addr_q;
    assign bus.dataIM = data_q;

    // Gating with rst_n drops a response already in stage 2 when reset hits.
    assign rsp_live            = rst_n & s2_q.valid;
    assign fetch_ok            = rsp_live & (s2_q.kind == FETCH) & ~s2_q.err;
    assign bus.fetch_rsp_valid = rsp_live & (s2_q.kind == FETCH);
    assign bus.fetch_rsp_err   = rsp_live & (s2_q.kind == FETCH) & s2_q.err;
    assign bus.fetch_rsp_data  = fetch_ok ? bus.outIM : '0;
    assign bus.load_done       = rsp_live & (s2_q.kind == LOAD);
    assign bus.load_err        = rsp_live & (s2_q.kind == LOAD) & s2_q.err;

endmodule
